alarm_arbiter: RTL and testbench

- Multi-channel alarm controller for the sensor-alarm path.
- Runs one consecutive-high detector per sensor input and latches each trigger as a sticky pending request.
- Grants the single shared alarm output to one channel at a time, round-robin, holding it until the alarm handler acknowledges.
- Sits between raw sensor sample lines and the alarm/siren handler.

---
 rtl/alarm_arbiter.sv | 132 +++++++++++++
 tb/tb_alarm_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_arbiter.sv
// Multi-channel sensor alarm arbiter: per-channel run-length trigger detectors feed
// sticky pending flags, and one shared alarm output is granted round-robin until acked.
module alarm_arbiter #(
  parameter int N      = 4,
  parameter int THRESH = 3,
  parameter int CW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [N-1:0]  d,
  input  logic          ack,
  output logic          alarm,
  output logic [CW-1:0] alarm_id,
  output logic [N-1:0]  pending,
  output logic          dropped
);

  localparam int CNTW = $clog2(THRESH + 1);
  localparam logic [CNTW-1:0] THR    = CNTW'(THRESH);
  localparam logic [CNTW-1:0] THR_M1 = CNTW'(THRESH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ALARM = 1'b1;

  logic [CNTW-1:0] cnt_q [N];
  logic [CNTW-1:0] cnt_d [N];
  logic [N-1:0]    pending_q, pending_d;
  logic            dropped_q, dropped_d;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   alarm_id_q, alarm_id_d;
  logic [CW-1:0]   last_q, last_d;

  logic [N-1:0]    trig;
  logic [N-1:0]    clr;
  logic [CW-1:0]   sel;

  // Saturating run counter: a saturated run sits at THRESH so it cannot re-trigger.
  function automatic logic [CNTW-1:0] run_next(input logic [CNTW-1:0] cnt,
                                               input logic            hi);
    if (!hi) begin
      return '0;
    end
    if (cnt == THR) begin
      return THR;
    end
    return cnt + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = run_next(cnt_q[i], enable & d[i]);
      trig[i]  = enable & d[i] & (cnt_q[i] == THR_M1);
      clr[i]   = (state_q == ALARM) & ack & (alarm_id_q == CW'(i));
    end
  end

  // A set in the same cycle as a clear wins, so the channel gets served again later.
  always_comb begin
    pending_d = trig | (pending_q & ~clr);
    dropped_d = |(trig & pending_q & ~clr);
  end

  // Round-robin pick: smallest distance past the last granted channel wins.
  always_comb begin
    int best;
    int rank;
    best = N + 1;
    rank = 0;
    sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(last_q)) begin
        rank = i - int'(last_q);
      end else begin
        rank = i + N - int'(last_q);
      end
      if (pending_q[i] && (rank < best)) begin
        best = rank;
        sel  = CW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    alarm_id_d = alarm_id_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d    = ALARM;
          alarm_id_d = sel;
          last_d     = sel;
        end
      end
      ALARM: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q  <= '0;
      dropped_q  <= 1'b0;
      state_q    <= IDLE;
      alarm_id_q <= '0;
      last_q     <= CW'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
      state_q    <= state_d;
      alarm_id_q <= alarm_id_d;
      last_q     <= last_d;
    end
  end

  assign alarm    = (state_q == ALARM);
  assign alarm_id = alarm_id_q;
  assign pending  = pending_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_alarm_arbiter.sv
// Bench for alarm_arbiter: directed scenarios plus randomized traffic against a
// run-length / grant-queue reference model.
module tb_alarm_arbiter;

  localparam int N      = 4;
  localparam int THRESH = 3;
  localparam int CW     = 2;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  d      = '0;
  logic          ack    = 1'b0;
  logic          alarm;
  logic [CW-1:0] alarm_id;
  logic [N-1:0]  pending;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain run lengths and a grant owner.
  int           run [N];
  bit [N-1:0]   m_pend;
  bit           m_busy;
  bit           m_drop;
  int           m_owner;
  int           m_last;

  always #5 clk = ~clk;

  alarm_arbiter #(.N(N), .THRESH(THRESH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .d        (d),
    .ack      (ack),
    .alarm    (alarm),
    .alarm_id (alarm_id),
    .pending  (pending),
    .dropped  (dropped)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) run[i] = 0;
    m_pend  = '0;
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
  endtask

  // One clock edge of the spec's rules, using the inputs currently applied.
  task automatic model_edge();
    bit [N-1:0] trig;
    bit [N-1:0] clr;
    bit [N-1:0] old;
    bit         found;
    int         idx;
    old   = m_pend;
    clr   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      trig[i] = enable && d[i] && (run[i] + 1 == THRESH);
    if (m_busy && ack) clr[m_owner] = 1'b1;
    m_drop = |(trig & old & ~clr);
    m_pend = trig | (old & ~clr);
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && old[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_last  = idx;
          m_busy  = 1'b1;
        end
      end
    end else if (ack) begin
      m_busy = 1'b0;
    end
    for (int i = 0; i < N; i++)
      run[i] = (enable && d[i]) ? run[i] + 1 : 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    d      = '0;
    ack    = 1'b0;
    reset  = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({alarm, alarm_id, pending, dropped} !== '0) begin
      errors++;
      $display("FAIL reset_async_pre_clock got=%b want=0", {alarm, alarm_id, pending, dropped});
    end
    apply_reset();
    for (int c = 0; c < 3; c++) step();
    checks++;
    if ({alarm, alarm_id, pending, dropped} !== '0) begin
      errors++;
      $display("FAIL reset_idle got=%b want=0", {alarm, alarm_id, pending, dropped});
    end
  endtask

  task automatic test_single();
    apply_reset();
    enable = 1'b1;
    d = 4'b0100;
    step(); step(); step();
    checks++;
    if (pending !== 4'b0100 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL single_pending got=%b alarm=%b want=0100 alarm=0", pending, alarm);
    end
    d = '0;
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd2) begin
      errors++;
      $display("FAIL single_grant got alarm=%b id=%0d want alarm=1 id=2", alarm, alarm_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (alarm !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack got alarm=%b pending=%b want 0 0000", alarm, pending);
    end
  endtask

  task automatic test_short_sat();
    int  grants;
    int  drops;
    bit  prev;
    apply_reset();
    enable = 1'b1;
    d = 4'b0010;
    step(); step();
    d = '0;
    step(); step();
    checks++;
    if (pending !== 4'b0000 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL short_run got pending=%b alarm=%b want 0000 0", pending, alarm);
    end
    grants = 0;
    drops  = 0;
    prev   = 1'b0;
    d = 4'b0010;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) d = '0;
      step();
      if (alarm && !prev) grants++;
      if (dropped) drops++;
      prev = alarm;
      ack  = alarm;
    end
    ack = 1'b0;
    checks++;
    if (grants != 1 || drops != 0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL saturation got grants=%0d drops=%0d pending=%b want 1 0 0000", grants, drops, pending);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int gap;
    bit prev;
    apply_reset();
    enable = 1'b1;
    d = 4'b1111;
    step(); step(); step();
    d = '0;
    checks++;
    if (pending !== 4'b1111) begin
      errors++;
      $display("FAIL rr_all_pending got=%b want=1111", pending);
    end
    gap  = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && !(ids.size() == 4 && !alarm); c++) begin
      step();
      if (alarm && !prev) begin
        ids.push_back(int'(alarm_id));
        if (ids.size() > 1) begin
          checks++;
          if (gap != 1) begin
            errors++;
            $display("FAIL rr_gap got=%0d idle cycles want=1", gap);
          end
        end
        gap = 0;
      end else if (!alarm) begin
        gap++;
      end
      prev = alarm;
      ack  = alarm;
    end
    ack = 1'b0;
    checks++;
    if (ids.size() != 4) begin
      errors++;
      $display("FAIL rr_grant_count got=%0d want=4", ids.size());
    end
    for (int i = 0; i < ids.size(); i++) begin
      checks++;
      if (ids[i] != i) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d want=%0d", i, ids[i], i);
      end
    end
  endtask

  task automatic test_pointer();
    enable = 1'b1;
    d = 4'b1001;
    step(); step(); step();
    d = '0;
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd0) begin
      errors++;
      $display("FAIL ptr_first got alarm=%b id=%0d want 1 0", alarm, alarm_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd3) begin
      errors++;
      $display("FAIL ptr_second got alarm=%b id=%0d want 1 3", alarm, alarm_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (pending !== 4'b0000 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL ptr_drain got pending=%b alarm=%b want 0000 0", pending, alarm);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    enable = 1'b1;
    d = 4'b0100;
    step(); step(); step();
    d = '0;
    step();
    d = 4'b0100;
    step(); step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    d = '0;
    checks++;
    if (pending !== 4'b0100 || dropped !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL collide_set_wins got pending=%b dropped=%b alarm=%b want 0100 0 0", pending, dropped, alarm);
    end
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd2) begin
      errors++;
      $display("FAIL collide_regrant got alarm=%b id=%0d want 1 2", alarm, alarm_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    d = 4'b0010;
    step(); step(); step();
    d = '0;
    step();
    d = 4'b0010;
    step(); step(); step();
    d = '0;
    checks++;
    if (dropped !== 1'b1 || pending !== 4'b0010 || alarm !== 1'b1 || alarm_id !== 2'd1) begin
      errors++;
      $display("FAIL drop_pulse got dropped=%b pending=%b alarm=%b id=%0d want 1 0010 1 1", dropped, pending, alarm, alarm_id);
    end
    step();
    checks++;
    if (dropped !== 1'b0 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL drop_one_cycle got dropped=%b pending=%b want 0 0010", dropped, pending);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen_alarm;
    apply_reset();
    enable = 1'b1;
    d = 4'b1010;
    step(); step(); step();
    d = '0;
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd1 || pending !== 4'b1010) begin
      errors++;
      $display("FAIL mid_setup got alarm=%b id=%0d pending=%b want 1 1 1010", alarm, alarm_id, pending);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (alarm !== 1'b0 || pending !== 4'b0000 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset got alarm=%b pending=%b dropped=%b want 0 0000 0", alarm, pending, dropped);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen_alarm = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (alarm) seen_alarm = 1'b1;
    end
    checks++;
    if (seen_alarm) begin
      errors++;
      $display("FAIL mid_quiet got alarm=1 want alarm=0 after release");
    end
    d = 4'b0101;
    step(); step(); step();
    d = '0;
    step();
    checks++;
    if (alarm !== 1'b1 || alarm_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_first_grant got alarm=%b id=%0d want 1 0", alarm, alarm_id);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_random();
    logic [CW-1:0]       m_id;
    logic [CW+N+1:0]     got;
    logic [CW+N+1:0]     want;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 9) < 7);
      ack = ($urandom_range(0, 2) == 0);
      step();
      m_id = m_owner[CW-1:0];
      got  = {alarm, alarm_id, pending, dropped};
      want = {m_busy, m_id, m_pend, m_drop};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle%0d got={alarm,id,pending,dropped}=%b want=%b", c, got, want);
      end
    end
    enable = 1'b0;
    d      = '0;
    ack    = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_short_sat();
    test_round_robin();
    test_pointer();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
